// File: rtl/bytecode_fetch.sv
// -----------------------------------------------------------------------------
// bytecode_fetch
//
// Upstream stage of the JVM bytecode decoder. Reads bytecode one byte at a time
// from a byte-wide memory. Sizes each instruction from its opcode and packs
// opcode plus operands into a left-aligned 32-bit word. Presents the word to
// the decoder with a start/ready handshake. Also accepts a control-transfer
// redirect from downstream.
//
// Ports
//   i_clk            clock, all state changes on the rising edge
//   i_reset          synchronous, active-high reset
//   i_enable         fetch permitted (only looked at while idle)
//   o_mem_rd         byte read request, held until i_mem_valid
//   o_mem_addr       byte address, stable while o_mem_rd is high
//   i_mem_data       read byte, qualified by i_mem_valid
//   i_mem_valid      read completes on this edge
//   o_instruction_out  opcode in [31:24], operands in the next lanes, rest zero
//   o_instr_pc       address of the opcode of o_instruction_out
//   o_start          word valid to the decoder
//   i_ready          decoder accepts the word
//   i_redirect       load a new fetch address
//   i_redirect_pc    the new fetch address
//   o_unsupported    sticky flag, an unsupported opcode was fetched
// -----------------------------------------------------------------------------
module bytecode_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [7:0]            i_mem_data,
  input  logic                  i_mem_valid,
  output logic [31:0]           o_instruction_out,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  output logic                  o_start,
  input  logic                  i_ready,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_unsupported
);

  localparam int BYTE      = 8;
  localparam int WIDTH_OUT = 4 * BYTE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_ARG,
    S_PRESENT,
    S_HALT
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [WIDTH_OUT-1:0]  r_word;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic [1:0]            r_remaining;   // operand bytes still to fetch
  logic [1:0]            r_lane;        // 1..3: next operand lane below the opcode
  logic                  r_unsupported;
  logic [2:0]            w_op_len;      // 0 marks an unsupported opcode

  // Instruction length in bytes, 0 for opcodes this stage cannot handle.
  function automatic logic [2:0] op_length(input logic [BYTE-1:0] op);
    logic [2:0] len;
    len = 3'd1;
    if (op == 8'hc5) begin
      len = 3'd4;
    end else if (op inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'ha8],
                            [8'hb2:8'hb8], 8'hbb, 8'hbd, 8'hc0, 8'hc1,
                            8'hc6, 8'hc7}) begin
      len = 3'd3;
    end else if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3a],
                            8'ha9, 8'hbc}) begin
      len = 3'd2;
    end else if (op inside {8'haa, 8'hab, 8'hb9, 8'hba, 8'hc4,
                            [8'hc8:8'hff]}) begin
      len = 3'd0;
    end
    return len;
  endfunction

  assign w_op_len = op_length(i_mem_data);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next_state = r_state;
    o_mem_rd     = 1'b0;
    o_mem_addr   = '0;
    o_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_next_state = S_FETCH_OP;
      end
      S_FETCH_OP: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = r_pc;
        // A redirect wins over a read completing in the same cycle.
        if (i_redirect) begin
          w_next_state = S_FETCH_OP;
        end else if (i_mem_valid) begin
          if (w_op_len == 3'd0)      w_next_state = S_HALT;
          else if (w_op_len == 3'd1) w_next_state = S_PRESENT;
          else                       w_next_state = S_FETCH_ARG;
        end
      end
      S_FETCH_ARG: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = r_pc;
        if (i_redirect) begin
          w_next_state = S_FETCH_OP;
        end else if (i_mem_valid && (r_remaining == 2'd1)) begin
          w_next_state = S_PRESENT;
        end
      end
      S_PRESENT: begin
        o_start = 1'b1;
        // A handshake coinciding with a redirect still counts as delivered.
        if (i_redirect || i_ready) w_next_state = S_FETCH_OP;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_word        <= '0;
      r_instr_pc    <= '0;
      r_remaining   <= '0;
      r_lane        <= '0;
      r_unsupported <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_PRESENT: begin
          if (i_redirect) r_pc <= i_redirect_pc;
        end
        S_FETCH_OP: begin
          if (i_redirect) begin
            r_pc <= i_redirect_pc;
          end else if (i_mem_valid) begin
            if (w_op_len == 3'd0) begin
              r_unsupported <= 1'b1;
            end else begin
              r_word      <= {i_mem_data, {(WIDTH_OUT - BYTE){1'b0}}};
              r_instr_pc  <= r_pc;
              r_pc        <= r_pc + 1'b1;
              r_remaining <= 2'(w_op_len - 3'd1);
              r_lane      <= 2'd1;
            end
          end
        end
        S_FETCH_ARG: begin
          if (i_redirect) begin
            r_pc <= i_redirect_pc;
          end else if (i_mem_valid) begin
            case (r_lane)
              2'd1:    r_word[23:16] <= i_mem_data;
              2'd2:    r_word[15:8]  <= i_mem_data;
              default: r_word[7:0]   <= i_mem_data;
            endcase
            r_pc        <= r_pc + 1'b1;
            r_remaining <= r_remaining - 2'd1;
            r_lane      <= r_lane + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_instruction_out = r_word;
  assign o_instr_pc        = r_instr_pc;
  assign o_unsupported     = r_unsupported;

endmodule

// File: tb/tb_bytecode_fetch.sv
// -----------------------------------------------------------------------------
// tb_bytecode_fetch
//
// Self-checking bench for bytecode_fetch. A byte memory with configurable wait
// states answers read requests. A table of single instructions checks packing
// and latency. Hand-written sequences cover handshake stalls, redirects, halt
// and address wrap. Randomised programs are checked against a program-walk
// model of the instruction stream.
// -----------------------------------------------------------------------------
module tb_bytecode_fetch;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        start;
  logic        ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        unsupported;

  bytecode_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_enable          (enable),
    .o_mem_rd          (mem_rd),
    .o_mem_addr        (mem_addr),
    .i_mem_data        (mem_data),
    .i_mem_valid       (mem_valid),
    .o_instruction_out (instr),
    .o_instr_pc        (instr_pc),
    .o_start           (start),
    .i_ready           (ready),
    .i_redirect        (redirect),
    .i_redirect_pc     (redirect_pc),
    .o_unsupported     (unsupported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  mem [0:65535];
  int          len_tab [256];
  int          wait_cfg   = 0;
  int          wait_cnt   = 0;
  int          ready_mode = 0;  // 0 always ready, 1 random, 2 never ready
  bit          score_en   = 1'b0;

  logic [31:0] log_word [$];
  logic [15:0] log_pc   [$];
  int          log_cyc  [$];
  logic [31:0] exp_word [$];
  logic [15:0] exp_pc   [$];

  typedef struct {
    logic [31:0] bytes;     // memory bytes 0..3, byte 0 in [31:24]
    logic [31:0] exp_word;
    int          exp_lat;   // cycles from reset release until start is seen
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic init_len_tab();
    for (int i = 0; i < 256; i++) len_tab[i] = 1;
    len_tab['h10] = 2; len_tab['h12] = 2; len_tab['ha9] = 2; len_tab['hbc] = 2;
    for (int i = 'h15; i <= 'h19; i++) len_tab[i] = 2;
    for (int i = 'h36; i <= 'h3a; i++) len_tab[i] = 2;
    len_tab['h11] = 3; len_tab['h13] = 3; len_tab['h14] = 3; len_tab['h84] = 3;
    len_tab['hbb] = 3; len_tab['hbd] = 3; len_tab['hc0] = 3; len_tab['hc1] = 3;
    len_tab['hc6] = 3; len_tab['hc7] = 3;
    for (int i = 'h99; i <= 'ha8; i++) len_tab[i] = 3;
    for (int i = 'hb2; i <= 'hb8; i++) len_tab[i] = 3;
    len_tab['hc5] = 4;
    len_tab['haa] = 0; len_tab['hab] = 0; len_tab['hb9] = 0; len_tab['hba] = 0;
    len_tab['hc4] = 0;
    for (int i = 'hc8; i <= 'hff; i++) len_tab[i] = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  // One clock: capture what the DUT sees at the edge, check after it, then
  // drive memory response and ready for the next edge.
  task automatic step();
    logic        a_start, a_ready, a_redir, a_reset, a_rd, a_valid, hs;
    logic [31:0] a_word, ew;
    logic [15:0] a_pc, a_addr, ep;
    a_start = start;  a_ready = ready;  a_redir = redirect; a_reset = reset;
    a_rd    = mem_rd; a_valid = mem_valid;
    a_word  = instr;  a_pc    = instr_pc; a_addr  = mem_addr;
    @(posedge clk);
    #1;
    cyc++;
    hs = a_start && a_ready && !a_reset;
    if (hs) begin
      log_word.push_back(a_word);
      log_pc.push_back(a_pc);
      log_cyc.push_back(cyc);
    end
    if (hs && score_en) begin
      check("rand_word_expected", 64'(exp_word.size() != 0), 64'd1);
      if (exp_word.size() != 0) begin
        ew = exp_word.pop_front();
        ep = exp_pc.pop_front();
        check("rand_word", 64'(a_word), 64'(ew));
        check("rand_pc", 64'(a_pc), 64'(ep));
      end
    end
    if (a_start && !hs && !a_redir && !a_reset)
      check("start_hold", {15'd0, start, instr, instr_pc}, {15'd0, 1'b1, a_word, a_pc});
    if (a_rd && !a_valid && !a_redir && !a_reset)
      check("addr_hold", {47'd0, mem_rd, mem_addr}, {47'd0, 1'b1, a_addr});

    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
    if (mem_rd === 1'b1) begin
      if (wait_cnt >= wait_cfg) begin
        mem_valid = 1'b1;
        mem_data  = mem[mem_addr];
        wait_cnt  = 0;
      end else begin
        mem_valid = 1'b0;
        mem_data  = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_valid = 1'b0;
      mem_data  = 8'($urandom);
      wait_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    step();
    step();
    reset = 1'b0;
    log_word.delete();
    log_pc.delete();
    log_cyc.delete();
  endtask

  task automatic wait_start(input string name, input int budget, output int n);
    n = 0;
    while (start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(start), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {29'd0, mem_rd, mem_addr, instr_pc, start, unsupported},
          64'd0);
    check({name, "_word"}, 64'(instr), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [15:0] base, p;
    logic [7:0]  op, b;
    logic [31:0] w;
    int          len;

    reset = 1'b1; enable = 1'b0; ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; mem_valid = 1'b0; mem_data = '0;
    init_len_tab();
    clear_mem();

    vecs[0]  = '{32'h03ee0000, 32'h03000000, 2};
    vecs[1]  = '{32'h107f0000, 32'h107f0000, 3};
    vecs[2]  = '{32'h11123400, 32'h11123400, 4};
    vecs[3]  = '{32'hc5010203, 32'hc5010203, 5};
    vecs[4]  = '{32'hbc0a9900, 32'hbc0a0000, 3};
    vecs[5]  = '{32'hb1ffffff, 32'hb1000000, 2};
    vecs[6]  = '{32'hc7aabb11, 32'hc7aabb00, 4};
    vecs[7]  = '{32'h3a05dd00, 32'h3a050000, 3};
    vecs[8]  = '{32'h8401ff77, 32'h8401ff00, 4};
    vecs[9]  = '{32'hbf123456, 32'hbf000000, 2};
    vecs[10] = '{32'ha8001099, 32'ha8001000, 4};
    vecs[11] = '{32'h19042222, 32'h19040000, 3};
    vecs[12] = '{32'h9955aa77, 32'h9955aa00, 4};
    vecs[13] = '{32'hc6010203, 32'hc6010200, 4};

    // Reset state.
    do_reset();
    check_all_zero("reset_state");

    // Single-instruction table: packing, opcode pc and latency.
    foreach (vecs[i]) begin
      for (int j = 0; j < 4; j++) mem[j] = vecs[i].bytes[31 - 8*j -: 8];
      wait_cfg = 0; ready_mode = 2; enable = 1'b1;
      do_reset();
      wait_start($sformatf("vec%0d_start", i), 20, n);
      check($sformatf("vec%0d_word", i), 64'(instr), 64'(vecs[i].exp_word));
      check($sformatf("vec%0d_pc", i), 64'(instr_pc), 64'd0);
      check($sformatf("vec%0d_latency", i), 64'(n), 64'(vecs[i].exp_lat));
    end

    // Back-to-back one-byte instructions with the decoder always ready.
    clear_mem();
    mem[0] = 8'h03; mem[1] = 8'h04;
    wait_cfg = 0; ready_mode = 0; enable = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("seq1_count", 64'(log_word.size() >= 2), 64'd1);
    if (log_word.size() >= 2) begin
      check("seq1_word0", 64'(log_word[0]), 64'h03000000);
      check("seq1_pc0", 64'(log_pc[0]), 64'd0);
      check("seq1_word1", 64'(log_word[1]), 64'h04000000);
      check("seq1_pc1", 64'(log_pc[1]), 64'd1);
      check("seq1_spacing", 64'(log_cyc[1] - log_cyc[0]), 64'd2);
    end

    // Multi-byte instructions, zero-wait then three wait states per byte.
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h7f; mem[2] = 8'h11; mem[3] = 8'h12; mem[4] = 8'h34;
    for (int k = 0; k < 2; k++) begin
      wait_cfg = (k == 0) ? 0 : 3; ready_mode = 0;
      do_reset();
      for (int i = 0; i < 40; i++) step();
      check("seq2_count", 64'(log_word.size() >= 2), 64'd1);
      if (log_word.size() >= 2) begin
        check("seq2_word0", 64'(log_word[0]), 64'h107f0000);
        check("seq2_pc0", 64'(log_pc[0]), 64'd0);
        check("seq2_word1", 64'(log_word[1]), 64'h11123400);
        check("seq2_pc1", 64'(log_pc[1]), 64'd2);
      end
    end

    // Decoder stalls for ten cycles: word held, no new read.
    clear_mem();
    mem[0] = 8'h6f;
    wait_cfg = 0; ready_mode = 2;
    do_reset();
    wait_start("seq3_start", 20, n);
    for (int i = 0; i < 10; i++) begin
      step();
      check("seq3_no_read", 64'(mem_rd), 64'd0);
    end
    check("seq3_word", {15'd0, start, instr, instr_pc}, {15'd0, 1'b1, 32'h6f000000, 16'd0});
    ready = 1'b1; ready_mode = 0;
    step();
    check("seq3_hs_count", 64'(log_word.size()), 64'd1);
    check("seq3_next_read", {47'd0, mem_rd, mem_addr}, {47'd0, 1'b1, 16'd1});

    // Redirect during operand fetch, then redirect coinciding with a handshake.
    clear_mem();
    mem[0] = 8'ha7; mem[1] = 8'h00; mem[2] = 8'h10;
    mem[16'h40] = 8'h03; mem[16'h80] = 8'h04;
    wait_cfg = 0; ready_mode = 2;
    do_reset();
    step();
    step();
    check("seq4_in_arg", {47'd0, mem_rd, mem_addr}, {47'd0, 1'b1, 16'd1});
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check("seq4_target", {46'd0, start, mem_rd, mem_addr}, {46'd0, 1'b0, 1'b1, 16'h0040});
    wait_start("seq4_start", 20, n);
    check("seq4_no_partial", 64'(log_word.size()), 64'd0);
    check("seq4_word", {16'd0, instr, instr_pc}, {16'd0, 32'h03000000, 16'h0040});
    ready = 1'b1; ready_mode = 0; redirect = 1'b1; redirect_pc = 16'h0080;
    step();
    redirect = 1'b0;
    check("seq4_hs_counted", 64'(log_word.size()), 64'd1);
    if (log_word.size() == 1)
      check("seq4_hs_word", {16'd0, log_word[0], log_pc[0]}, {16'd0, 32'h03000000, 16'h0040});
    check("seq4_redir_addr", {47'd0, mem_rd, mem_addr}, {47'd0, 1'b1, 16'h0080});
    wait_start("seq4_start2", 20, n);
    check("seq4_word2", {16'd0, instr, instr_pc}, {16'd0, 32'h04000000, 16'h0080});

    // Unsupported opcode at pc 5: halt, redirect ignored, reset recovers.
    clear_mem();
    mem[5] = 8'hc8;
    wait_cfg = 0; ready_mode = 0;
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("seq5_halt", {61'd0, unsupported, mem_rd, start}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("seq5_hs_count", 64'(log_word.size()), 64'd5);
    if (log_pc.size() == 5) check("seq5_last_pc", 64'(log_pc[4]), 64'd4);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    step();
    check("seq5_redir_ignored", {62'd0, unsupported, mem_rd}, {62'd0, 1'b1, 1'b0});
    do_reset();
    check("seq5_cleared", 64'(unsupported), 64'd0);
    step();
    check("seq5_restart", {47'd0, mem_rd, mem_addr}, {47'd0, 1'b1, 16'd0});

    // Idle redirect to the top address; operand fetch wraps to 0.
    clear_mem();
    mem[16'hffff] = 8'h10; mem[0] = 8'h55;
    wait_cfg = 0; ready_mode = 2; enable = 1'b0;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hffff;
    step();
    redirect = 1'b0;
    check("seq6_idle_stays", 64'(mem_rd), 64'd0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("seq6_top_addr", {47'd0, mem_rd, mem_addr}, {47'd0, 1'b1, 16'hffff});
    wait_start("seq6_start", 20, n);
    check("seq6_word", {16'd0, instr, instr_pc}, {16'd0, 32'h10550000, 16'hffff});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("seq6_reset_mid_present");
    enable = 1'b1;

    // Random programs with random waits and random decoder readiness.
    for (int r = 0; r < 8; r++) begin
      base = (r == 0) ? 16'hfff0 : 16'($urandom);
      p = base;
      exp_word.delete();
      exp_pc.delete();
      for (int k = 0; k < 40; k++) begin
        do op = 8'($urandom); while (len_tab[op] == 0);
        len = len_tab[op];
        w = {op, 24'd0};
        mem[p] = op;
        for (int j = 1; j < len; j++) begin
          b = 8'($urandom);
          mem[p + 16'(j)] = b;
          w = w | (32'(b) << (8 * (3 - j)));
        end
        exp_word.push_back(w);
        exp_pc.push_back(p);
        p = p + 16'(len);
      end
      wait_cfg = $urandom_range(0, 2); ready_mode = 1; enable = 1'b1;
      do_reset();
      score_en = 1'b1;
      redirect = 1'b1; redirect_pc = base;
      step();
      redirect = 1'b0;
      n = 0;
      while (exp_word.size() != 0 && n < 3000) begin
        step();
        n++;
      end
      score_en = 1'b0;
      check($sformatf("rand%0d_drained", r), 64'(exp_word.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bytecode_fetch.md
# bytecode_fetch

Upstream stage of the bytecode decoder. Reads JVM bytecode one byte at a time from a byte-wide bytecode memory and determines each instruction's length from its opcode. Packs opcode plus operands into a 32-bit left-aligned instruction word. Hands the word to the decoder over the decoder's `start`/`ready` handshake. Also accepts a control-transfer redirect from downstream.

## Interface

- `byte`, 8, bits per bytecode byte
- `width_out`, 32, instruction word width (4 × `byte`)
- `ADDR_WIDTH`, 16, bytecode address width
- `RESET_PC`, 0, first fetch address after reset

- `clk`  input  1  single clock; all state changes on rising edge
- `reset`  input  1  synchronous, active-high
- `enable`  input  1  fetch permitted; sampled only in IDLE
- `mem_rd`  output  1  byte read request
- `mem_addr`  output  ADDR_WIDTH  byte address, stable while `mem_rd` high
- `mem_data`  input  8  read byte, valid with `mem_valid`
- `mem_valid`  input  1  read complete this edge
- `instruction_out`  output  32  opcode in [31:24], operands in following bytes, unused bytes zero
- `instr_pc`  output  ADDR_WIDTH  address of the opcode of `instruction_out`
- `start`  output  1  word valid to decoder
- `ready`  input  1  decoder accepts
- `redirect`  input  1  load new fetch address
- `redirect_pc`  input  ADDR_WIDTH  new fetch address
- `unsupported`  output  1  sticky, unsupported opcode seen

## Operation

- Reset values: `mem_rd`=0, `mem_addr`=0, `instruction_out`=0, `instr_pc`=0, `start`=0, `unsupported`=0, internal pc=`RESET_PC`, state IDLE.
- States:
  - IDLE: go to FETCH_OP when `enable`=1.
  - FETCH_OP: `mem_rd`=1, `mem_addr`=pc. On `mem_valid`:
    - byte is written to [31:24] and [23:0] is cleared.
    - `instr_pc`<=pc and pc<=pc+1.
    - Length L is taken from the table. L=1 goes to PRESENT; otherwise go to FETCH_ARG with remaining count L-1.
  - FETCH_ARG: `mem_rd`=1, `mem_addr`=pc. Each `mem_valid` writes the next lower byte lane ([23:16], then [15:8], then [7:0]), pc<=pc+1, count-1. At count 0 go to PRESENT.
  - PRESENT: `start`=1, word held stable. On `start`&&`ready`: go to FETCH_OP, with `start`=0 from the next cycle.
  - HALT: entered on an unsupported opcode. The word is not presented. `unsupported`=1 and `mem_rd`=0 until reset.
- `mem_rd` stays high across the wait cycles until `mem_valid` is seen. `mem_valid` is ignored when `mem_rd`=0.
- Length table (all others L=1):
  - L=2: 0x10, 0x12, 0x15–0x19, 0x36–0x3a, 0xa9, 0xbc.
  - L=3: 0x11, 0x13, 0x14, 0x84, 0x99–0xa8, 0xb2–0xb8, 0xbb, 0xbd, 0xc0, 0xc1, 0xc6, 0xc7.
  - L=4: 0xc5.
  - Unsupported: 0xaa, 0xab, 0xb9, 0xba, 0xc4, 0xc8, 0xc9, 0xca–0xff.
- pc arithmetic is modulo 2^ADDR_WIDTH. Fetch past the top address wraps to 0.
- `redirect` in FETCH_OP, FETCH_ARG or PRESENT:
  - pc<=`redirect_pc`; any partial word is discarded; `start`<=0; next state FETCH_OP.
  - A `mem_valid` in the same cycle is dropped.
  - If `start`&&`ready`&&`redirect` occur together, the transfer counts (the decoder owns the word) and pc still loads `redirect_pc`.
  - In IDLE: only pc loads. In HALT: ignored.
- `reset` overrides everything, in any state, mid-read or mid-present.

## Timing

- Zero-wait memory (`mem_valid` on the first `mem_rd` cycle): an L-byte instruction reaches PRESENT L cycles after entering FETCH_OP. `start` rises on the following edge.
- With the decoder always ready, throughput is one instruction per L+1 cycles.
- `instruction_out`/`instr_pc` change only on capture edges. They are stable for the whole time `start`=1.
- `start` never drops without a handshake, except on `redirect` or `reset`.
- `enable` deassertion outside IDLE has no effect.

## Test plan

- Memory 0x03, 0x04, zero-wait, `ready`=1 → words 0x03000000 (instr_pc 0), then 0x04000000 (instr_pc 1); `start` high one cycle each, 2 cycles apart.
- Memory 0x10 0x7f 0x11 0x12 0x34 → 0x107f0000 (pc 0), then 0x11123400 (pc 2). Repeat with `mem_valid` delayed 3 cycles per byte → same words; `mem_addr` held during the waits.
- `ready`=0 for 10 cycles on 0x6f → `start` and 0x6f000000 stay stable; no `mem_rd` issued until the handshake.
- `redirect` to 0x0040 mid-FETCH_ARG of 0xa7 → no partial word emitted; next `mem_addr`=0x0040. Simultaneous handshake+redirect → word counted, next fetch from the target.
- Opcode 0xc8 at pc 5 → `unsupported`=1, `start` never asserted, `mem_rd`=0. `reset` then clears it and fetch restarts at `RESET_PC`.
- pc at 0xffff with opcode 0x10 → operand fetched from 0x0000. `reset` asserted while `start`=1 → all outputs 0 the next cycle.
